// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and address mask.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2,
      S_FULL  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC -> imem req/ack -> instruction register for decode.
// Flushed fetches still wait for their ack so memory sees a stable address.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int RESET_HOLD = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pc_in,
   output logic             pc_adv,
   input  logic             flush,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic             ir_valid,
   input  logic             ir_ready,
   output logic [31:0]      ir_data,
   output logic [31:0]      ir_pc,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [7:0] HOLD_M1 = (RESET_HOLD > 0) ? 8'(RESET_HOLD - 1) : 8'd0;

   fetch_state_t state;
   logic [7:0]   idle_cnt;
   logic [31:0]  fetch_pc;
   logic [31:0]  pc_word;
   logic         busy;

   assign pc_word   = pc_in & WORD_MASK;
   assign busy      = (state == S_REQ) || (state == S_DRAIN);
   // DRAIN keeps presenting the abandoned address until its ack returns.
   assign imem_addr = (state == S_REQ) ? pc_word : fetch_pc;
   assign pc_adv    = (state == S_REQ) && imem_ack && !flush;

   sat_counter #(.W(CNT_W)) u_stall (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .inc (busy && !imem_ack),
      .cnt (stall_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         imem_req <= 1'b0;
         ir_valid <= 1'b0;
         ir_data  <= '0;
         ir_pc    <= '0;
         fetch_pc <= '0;
         idle_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (idle_cnt >= HOLD_M1) begin
                  state    <= S_REQ;
                  imem_req <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 8'd1;
               end
            end
            S_REQ: begin
               fetch_pc <= pc_word;
               if (imem_ack && !flush) begin
                  ir_data  <= imem_rdata;
                  ir_pc    <= pc_word;
                  ir_valid <= 1'b1;
                  imem_req <= 1'b0;
                  state    <= S_FULL;
               end else if (!imem_ack && flush) begin
                  state    <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (imem_ack)
                  state <= S_REQ;
            end
            S_FULL: begin
               // flush and ready both release the register; flush just wins logically.
               if (flush || ir_ready) begin
                  ir_valid <= 1'b0;
                  imem_req <= 1'b1;
                  state    <= S_REQ;
               end
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage between the program counter and the decode/control logic of the single-cycle MIPS datapath. It uses the current PC to issue a word read to instruction memory over a req/ack handshake, then holds the returned instruction for decode under valid/ready. It pulses pc_adv to let the PC advance once per accepted fetch. Branch/jump redirects arrive as flush; any in-flight fetch is drained and discarded.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter
RESET_HOLD, 1, cycles spent in IDLE after reset deasserts before the first request

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_in  in  32  current PC (program counter Out)
pc_adv  out  1  combinational; high for one cycle when the PC may step +4
flush  in  1  redirect taken (branch/jump/WrEn load of PC this edge)
imem_req  out  1  registered read request
imem_addr  out  32  word-aligned read address
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_ack
ir_valid  out  1  ir_data/ir_pc hold an instruction for decode
ir_ready  in  1  decode accepts the instruction this cycle
ir_data  out  32  fetched instruction
ir_pc  out  32  address ir_data was fetched from
stall_cnt  out  CNT_W  cycles spent in REQ or DRAIN, saturating

Behaviour:
- Reset (async, any state): state=IDLE, imem_req=0, ir_valid=0, ir_data=0, ir_pc=0, fetch_pc=0, stall_cnt=0, idle counter=0.
- States: IDLE, REQ, DRAIN, FULL. imem_req=1 exactly in REQ and DRAIN.
- IDLE: counts RESET_HOLD cycles, then goes to REQ. flush is ignored.
- imem_addr = pc_in & ~3 in REQ. In DRAIN it is fetch_pc. fetch_pc <= pc_in & ~3 every REQ cycle.
- REQ, imem_ack=1, flush=0: ir_data<=imem_rdata, ir_pc<=pc_in&~3, ir_valid<=1, goto FULL. pc_adv=1 this cycle and only here. The PC updates at the same edge, so pc_in is new from the next cycle.
- REQ, ack=1, flush=1: data discarded, pc_adv=0, stay REQ. The next request uses the redirected pc_in.
- REQ, ack=0, flush=1: goto DRAIN. The request stays up at the old address until ack.
- REQ, ack=0, flush=0: stay REQ.
- DRAIN: on ack, discard data and goto REQ. flush in DRAIN keeps state DRAIN.
- FULL: ir_data/ir_pc/ir_valid are stable while ir_ready=0.
  - ir_valid&ir_ready: ir_valid<=0, goto REQ.
  - flush (priority over ready): ir_valid<=0, goto REQ.
- Priority: rst > flush > imem_ack / ir_ready.
- Throughput: best case one instruction per 2 cycles (REQ with ack, FULL with ready).
- stall_cnt increments each cycle the state is REQ or DRAIN and imem_ack=0. It saturates at all-ones.
- imem_ack outside REQ/DRAIN is ignored.
- The memory contract requires imem_addr to be stable while imem_req=1 and ack=0. This holds because pc_adv=0 unless ack, and DRAIN uses fetch_pc.

Decomposition:
- Shared package/include: state encoding constants (IDLE=2'd0, REQ=2'd1, DRAIN=2'd2, FULL=2'd3) and the WORD_MASK constant 32'hFFFF_FFFC.
- One sub-module is natural: sat_counter (parameterised width, inc, clr, saturating). It is used for stall_cnt and reusable elsewhere.
- Everything else stays in fetch_unit.

Test Plan:
1. Zero-wait memory (ack the cycle after req rises), ir_ready=1, pc_in starts 0 and steps +4 on pc_adv.
   - Required: ir_pc sequence 0,4,8,12 with ir_data matching memory.
   - Required: one pc_adv per instruction, stall_cnt stays 0.
2. Memory with 3-cycle ack latency at pc_in=0x40.
   - Required: imem_addr=0x40 held for 3 cycles, stall_cnt=3.
   - Required: ir_data captured on ack, pc_adv pulses once.
3. ir_ready held 0 for 5 cycles after fetching 0x8C220004.
   - Required: ir_valid=1 with ir_data/ir_pc stable for all 5 cycles.
   - Required: no new imem_req; REQ is entered the cycle after ready=1.
4. flush in REQ without ack at pc_in=0x10, redirect to 0x100, ack 2 cycles later.
   - Required: imem_addr stays 0x10 through DRAIN and the data is discarded.
   - Required: next request addr=0x100, ir_pc=0x100, no pc_adv for the dropped fetch.
5. flush and ack in the same REQ cycle.
   - Required: ir_valid stays 0, pc_adv=0, the next request uses the new pc_in.
   - Also: flush in FULL clears ir_valid next cycle regardless of ir_ready.
6. rst asserted asynchronously mid-DRAIN.
   - Required: all outputs zero immediately and IDLE for RESET_HOLD cycles.
   - Required: the first request after release uses the pc_in value present at that time.
